apb2axi_wdf: RTL and testbench
==============================

# apb2axi_wdf

Write Data FIFO for the APB-to-AXI bridge. It buffers per-beat write data that the APB-side register logic pushes, and drains the data onto the AXI W channel one burst at a time. WLAST is generated from a per-burst beat count supplied by the write-address issuer. It is the write-direction counterpart of the read data FIFO and sits between the APB write-data path and the AXI master W port.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥ 2
- DATA_W, 64, AXI data width
- TAG_W, 4, burst tag width
- LEN_W, 8, AXI burst length field width (beats − 1)

Ports:
- ACLK  in  1  single clock for the whole block
- ARESET  in  1  asynchronous, active-high reset
- wr_push_valid  in  1  APB side offers a write beat
- wr_push_data  in  DATA_W  beat data
- wr_push_strb  in  DATA_W/8  beat byte strobes
- wr_push_ready  out  1  FIFO can accept a beat
- burst_valid  in  1  burst descriptor offered
- burst_tag  in  TAG_W  burst tag
- burst_len  in  LEN_W  beats − 1
- burst_ready  out  1  descriptor accepted when high with burst_valid
- WVALID  out  1  AXI W valid
- WDATA  out  DATA_W  AXI W data
- WSTRB  out  DATA_W/8  AXI W strobes
- WLAST  out  1  last beat of current burst
- WREADY  in  1  AXI W ready
- burst_done  out  1  one-cycle pulse: last beat of a burst has been accepted
- burst_done_tag  out  TAG_W  tag of the completed burst
- wdf_count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- FIFO: memory array with read/write pointers of $clog2(DEPTH)+1 bits; the MSB disambiguates full from empty; pointers wrap naturally.
- Push handshake: wr_push_valid && wr_push_ready. wr_push_ready = !full. Pops in the same cycle do not free a slot for a push when full; there is no bypass.
- Entry holds {data, strb}. The head entry drives WDATA/WSTRB combinationally from the registered array.
- FSM states:
  - IDLE: burst_ready=1, WVALID=0. On burst_valid, load beat_cnt=burst_len, cur_tag=burst_tag, and go to SEND.
  - SEND: burst_ready=0. WVALID=!empty. WLAST=(beat_cnt==0). On WVALID&&WREADY, pop the head. If beat_cnt==0, pulse burst_done with burst_done_tag=cur_tag and go to IDLE; otherwise beat_cnt−1.
- A new descriptor is not accepted in the cycle burst_done pulses; it is accepted in the following IDLE cycle.
- SEND with empty FIFO: WVALID low and beat_cnt held; the block waits indefinitely.
- WVALID, once asserted, stays high with stable WDATA/WSTRB/WLAST until WREADY. This holds by construction because only a W handshake pops the FIFO.
- Simultaneous push and pop when neither full nor empty: both take effect and wdf_count is unchanged.
- ARESET mid-burst flushes the FIFO, returns the FSM to IDLE, and discards the pending descriptor and beats.

## Timing
- Reset values: wr_push_ready=1, burst_ready=1, WVALID=0, WDATA=0, WSTRB=0, WLAST=0, burst_done=0, burst_done_tag=0, wdf_count=0.
- Push at edge N: wdf_count increments and the entry becomes visible at N+1. If the block is in SEND, WVALID rises at N+1 (one-cycle latency).
- Descriptor accepted at edge N: the state is SEND at N+1. WVALID is high at N+1 if the FIFO is non-empty.
- Back-to-back beats: one beat per cycle while WREADY=1 and the FIFO is non-empty.
- burst_done is registered and high for exactly the cycle after the last W handshake edge.

## Configuration
- APB2AXI_WDF_STRB_EN defined: strobes are stored per entry and WSTRB follows the head entry.
- APB2AXI_WDF_STRB_EN undefined: wr_push_strb is ignored, no strobe storage is built, and WSTRB is all ones whenever WVALID is high (0 at reset/idle).

## Test plan
- Push 4 beats D0..D3, then descriptor len=3, tag=5, WREADY=1: W beats D0..D3 on 4 consecutive cycles, WLAST only on D3, burst_done with tag 5 one cycle later, wdf_count back to 0.
- Descriptor len=1 before any data, then push 2 beats: WVALID=0 until the first push +1 cycle. Toggle WREADY 1,0,1: data is held stable during the stall and WLAST is on the 2nd beat.
- Push DEPTH=8 beats with no descriptor: wr_push_ready=0 and wdf_count=8. A 9th push is not accepted. After one W handshake, wr_push_ready returns to 1 the next cycle.
- Two descriptors (len=0, tag=1; len=2, tag=2) with 4 beats queued: the first WLAST is on beat 0 with burst_done tag 1. burst_ready is held 1 cycle, then the second burst ends on beat 3 with tag 2.
- Push 20 beats continuously while draining 20 via len=19 (wrap-around): order is preserved, there are no drops, and wdf_count never exceeds 8.
- Assert ARESET mid-burst after 2 of 4 beats: all outputs return to reset values immediately and wdf_count=0. A subsequent fresh burst operates normally.

Source files
------------

// File: rtl/apb2axi_wdf.sv
// Write data FIFO for the APB-to-AXI bridge: buffers APB write beats and drains them as AXI W bursts.
// Optional macro APB2AXI_WDF_STRB_EN stores per-beat strobes; otherwise WSTRB is all ones while WVALID.
module apb2axi_wdf #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4,
    parameter int LEN_W  = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      wr_push_valid,
    input  logic [DATA_W-1:0]         wr_push_data,
    input  logic [DATA_W/8-1:0]       wr_push_strb,
    output logic                      wr_push_ready,
    input  logic                      burst_valid,
    input  logic [TAG_W-1:0]          burst_tag,
    input  logic [LEN_W-1:0]          burst_len,
    output logic                      burst_ready,
    output logic                      WVALID,
    output logic [DATA_W-1:0]         WDATA,
    output logic [DATA_W/8-1:0]       WSTRB,
    output logic                      WLAST,
    input  logic                      WREADY,
    output logic                      burst_done,
    output logic [TAG_W-1:0]          burst_done_tag,
    output logic [$clog2(DEPTH):0]    wdf_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = DATA_W / 8;

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [LEN_W-1:0]  beat_cnt_q;
    logic [TAG_W-1:0]  cur_tag_q;
    logic [TAG_W-1:0]  done_tag_q;
    logic              done_q;

    logic [DATA_W-1:0] mem_data_q [DEPTH];

    logic empty, full, push, pop;

    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push   = wr_push_valid && !full;
    assign pop    = (state_q == SEND) && !empty && WREADY;
    assign wptr_d = wptr_q + PW'(push);
    assign rptr_d = rptr_q + PW'(pop);

    // Head entry is masked while WVALID is low so idle outputs read as zero.
    assign wr_push_ready  = !full;
    assign burst_ready    = (state_q == IDLE) && !done_q;
    assign WVALID         = (state_q == SEND) && !empty;
    assign WDATA          = WVALID ? mem_data_q[rptr_q[AW-1:0]] : '0;
    assign WLAST          = (state_q == SEND) && (beat_cnt_q == '0);
    assign burst_done     = done_q;
    assign burst_done_tag = done_tag_q;
    assign wdf_count      = wptr_q - rptr_q;

    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_data_q[wptr_q[AW-1:0]] <= wr_push_data;
        end
    end

`ifdef APB2AXI_WDF_STRB_EN
    logic [SW-1:0] mem_strb_q [DEPTH];

    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_strb_q[wptr_q[AW-1:0]] <= wr_push_strb;
        end
    end

    assign WSTRB = WVALID ? mem_strb_q[rptr_q[AW-1:0]] : '0;
`else
    logic unused_strb;
    assign unused_strb = ^wr_push_strb;
    assign WSTRB       = {SW{WVALID}};
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            beat_cnt_q <= '0;
            cur_tag_q  <= '0;
            done_tag_q <= '0;
            done_q     <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (burst_valid && burst_ready) begin
                        beat_cnt_q <= burst_len;
                        cur_tag_q  <= burst_tag;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (pop) begin
                        if (beat_cnt_q == '0) begin
                            done_q     <= 1'b1;
                            done_tag_q <= cur_tag_q;
                            state_q    <= IDLE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q - LEN_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb2axi_wdf.sv
// Directed self-checking bench for apb2axi_wdf; expected values are hand-derived per step.
module tb_apb2axi_wdf;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        wr_push_valid;
    logic [63:0] wr_push_data;
    logic [7:0]  wr_push_strb;
    logic        wr_push_ready;
    logic        burst_valid;
    logic [3:0]  burst_tag;
    logic [7:0]  burst_len;
    logic        burst_ready;
    logic        WVALID;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WLAST;
    logic        WREADY;
    logic        burst_done;
    logic [3:0]  burst_done_tag;
    logic [3:0]  wdf_count;

    int checks   = 0;
    int failures = 0;

    apb2axi_wdf #(.DEPTH(8), .DATA_W(64), .TAG_W(4), .LEN_W(8)) dut (
        .ACLK           (ACLK),
        .ARESET         (ARESET),
        .wr_push_valid  (wr_push_valid),
        .wr_push_data   (wr_push_data),
        .wr_push_strb   (wr_push_strb),
        .wr_push_ready  (wr_push_ready),
        .burst_valid    (burst_valid),
        .burst_tag      (burst_tag),
        .burst_len      (burst_len),
        .burst_ready    (burst_ready),
        .WVALID         (WVALID),
        .WDATA          (WDATA),
        .WSTRB          (WSTRB),
        .WLAST          (WLAST),
        .WREADY         (WREADY),
        .burst_done     (burst_done),
        .burst_done_tag (burst_done_tag),
        .wdf_count      (wdf_count)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] strb_of(input logic [63:0] d);
        return d[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] exp_strb(input logic [63:0] d);
`ifdef APB2AXI_WDF_STRB_EN
        return strb_of(d);
`else
        return strb_of(d) | 8'hFF;
`endif
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] d);
        wr_push_valid = 1'b1;
        wr_push_data  = d;
        wr_push_strb  = strb_of(d);
        tick();
        wr_push_valid = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [63:0] d, input logic last);
        check({tag, "_wvalid"}, 64'(WVALID), 64'd1);
        check({tag, "_wdata"},  WDATA, d);
        check({tag, "_wstrb"},  64'(WSTRB), 64'(exp_strb(d)));
        check({tag, "_wlast"},  64'(WLAST), 64'(last));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_push_ready"}, 64'(wr_push_ready), 64'd1);
        check({tag, "_burst_ready"}, 64'(burst_ready), 64'd1);
        check({tag, "_wvalid"}, 64'(WVALID), 64'd0);
        check({tag, "_wdata"}, WDATA, 64'd0);
        check({tag, "_wstrb"}, 64'(WSTRB), 64'd0);
        check({tag, "_wlast"}, 64'(WLAST), 64'd0);
        check({tag, "_done"}, 64'(burst_done), 64'd0);
        check({tag, "_done_tag"}, 64'(burst_done_tag), 64'd0);
        check({tag, "_count"}, 64'(wdf_count), 64'd0);
    endtask

    initial begin
        int b;
        int k;
        int cyc;
        wr_push_valid = 1'b0;
        wr_push_data  = '0;
        wr_push_strb  = '0;
        burst_valid   = 1'b0;
        burst_tag     = '0;
        burst_len     = '0;
        WREADY        = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        check_reset("rst");
        ARESET = 1'b0;
        tick();

        // Data first, then descriptor len=3 tag=5
        for (int i = 0; i < 4; i++) push(64'hA0 + 64'(i));
        check("t1_count4", 64'(wdf_count), 64'd4);
        check("t1_idle_wvalid", 64'(WVALID), 64'd0);
        WREADY = 1'b1;
        burst_valid = 1'b1; burst_len = 8'd3; burst_tag = 4'd5;
        check("t1_burst_ready", 64'(burst_ready), 64'd1);
        tick();
        burst_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat($sformatf("t1_b%0d", i), 64'hA0 + 64'(i), i == 3);
            tick();
        end
        check("t1_done", 64'(burst_done), 64'd1);
        check("t1_done_tag", 64'(burst_done_tag), 64'd5);
        check("t1_count0", 64'(wdf_count), 64'd0);
        check("t1_ready_in_done", 64'(burst_ready), 64'd0);
        check("t1_wvalid_after", 64'(WVALID), 64'd0);
        tick();
        check("t1_done_clear", 64'(burst_done), 64'd0);
        check("t1_ready_back", 64'(burst_ready), 64'd1);
        WREADY = 1'b0;

        // Descriptor before data, WREADY stall mid-burst
        burst_valid = 1'b1; burst_len = 8'd1; burst_tag = 4'd3;
        tick();
        burst_valid = 1'b0;
        check("t2_wvalid_empty0", 64'(WVALID), 64'd0);
        tick();
        check("t2_wvalid_empty1", 64'(WVALID), 64'd0);
        wr_push_valid = 1'b1; wr_push_data = 64'hB0; wr_push_strb = strb_of(64'hB0);
        tick();
        beat("t2_b0", 64'hB0, 1'b0);
        wr_push_data = 64'hB1; wr_push_strb = strb_of(64'hB1);
        WREADY = 1'b1;
        tick();
        wr_push_valid = 1'b0;
        beat("t2_b1", 64'hB1, 1'b1);
        WREADY = 1'b0;
        tick();
        beat("t2_stall0", 64'hB1, 1'b1);
        tick();
        beat("t2_stall1", 64'hB1, 1'b1);
        WREADY = 1'b1;
        tick();
        check("t2_done", 64'(burst_done), 64'd1);
        check("t2_done_tag", 64'(burst_done_tag), 64'd3);
        check("t2_wvalid_after", 64'(WVALID), 64'd0);
        WREADY = 1'b0;
        tick();

        // Fill to DEPTH, reject 9th push, free one slot
        for (int i = 0; i < 8; i++) push(64'hC0 + 64'(i));
        check("t3_full_ready", 64'(wr_push_ready), 64'd0);
        check("t3_full_count", 64'(wdf_count), 64'd8);
        wr_push_valid = 1'b1; wr_push_data = 64'hC8; wr_push_strb = strb_of(64'hC8);
        tick();
        wr_push_valid = 1'b0;
        check("t3_ninth_count", 64'(wdf_count), 64'd8);
        check("t3_ninth_ready", 64'(wr_push_ready), 64'd0);
        burst_valid = 1'b1; burst_len = 8'd7; burst_tag = 4'd7;
        tick();
        burst_valid = 1'b0;
        beat("t3_b0", 64'hC0, 1'b0);
        WREADY = 1'b1;
        tick();
        WREADY = 1'b0;
        check("t3_ready_after_pop", 64'(wr_push_ready), 64'd1);
        check("t3_count7", 64'(wdf_count), 64'd7);
        WREADY = 1'b1;
        for (int i = 1; i < 8; i++) begin
            beat($sformatf("t3_b%0d", i), 64'hC0 + 64'(i), i == 7);
            tick();
        end
        check("t3_done", 64'(burst_done), 64'd1);
        check("t3_done_tag", 64'(burst_done_tag), 64'd7);
        check("t3_count0", 64'(wdf_count), 64'd0);
        WREADY = 1'b0;
        tick();

        // Two descriptors back to back: len=0 tag=1, len=2 tag=2
        for (int i = 0; i < 4; i++) push(64'hD0 + 64'(i));
        burst_valid = 1'b1; burst_len = 8'd0; burst_tag = 4'd1;
        tick();
        burst_valid = 1'b0;
        WREADY = 1'b1;
        beat("t4_single", 64'hD0, 1'b1);
        tick();
        check("t4_done1", 64'(burst_done), 64'd1);
        check("t4_done1_tag", 64'(burst_done_tag), 64'd1);
        check("t4_ready_blocked", 64'(burst_ready), 64'd0);
        burst_valid = 1'b1; burst_len = 8'd2; burst_tag = 4'd2;
        tick();
        check("t4_ready_again", 64'(burst_ready), 64'd1);
        check("t4_not_taken_wvalid", 64'(WVALID), 64'd0);
        check("t4_done_clear", 64'(burst_done), 64'd0);
        tick();
        burst_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            beat($sformatf("t4_b%0d", i), 64'hD0 + 64'(i), i == 3);
            tick();
        end
        check("t4_done2", 64'(burst_done), 64'd1);
        check("t4_done2_tag", 64'(burst_done_tag), 64'd2);
        check("t4_count0", 64'(wdf_count), 64'd0);
        tick();

        // Streaming 20 beats through len=19 (pointer wrap)
        burst_valid = 1'b1; burst_len = 8'd19; burst_tag = 4'd9;
        tick();
        burst_valid = 1'b0;
        b = 0; k = 0; cyc = 0;
        while (b < 20 && cyc < 60) begin
            if (k < 20) begin
                wr_push_valid = 1'b1;
                wr_push_data  = 64'h1000 + 64'(k);
                wr_push_strb  = strb_of(64'h1000 + 64'(k));
                k++;
            end else begin
                wr_push_valid = 1'b0;
            end
            check($sformatf("t5_count_c%0d", cyc), 64'(wdf_count), (cyc == 0) ? 64'd0 : 64'd1);
            if (WVALID) begin
                beat($sformatf("t5_b%0d", b), 64'h1000 + 64'(b), b == 19);
                b++;
            end
            tick();
            cyc++;
        end
        wr_push_valid = 1'b0;
        check("t5_cycles", 64'(cyc), 64'd21);
        check("t5_beats", 64'(b), 64'd20);
        check("t5_done", 64'(burst_done), 64'd1);
        check("t5_done_tag", 64'(burst_done_tag), 64'd9);
        check("t5_count0", 64'(wdf_count), 64'd0);
        WREADY = 1'b0;
        tick();

        // Reset mid-burst, then a fresh burst
        for (int i = 0; i < 4; i++) push(64'hE0 + 64'(i));
        burst_valid = 1'b1; burst_len = 8'd3; burst_tag = 4'd6;
        tick();
        burst_valid = 1'b0;
        WREADY = 1'b1;
        beat("t6_b0", 64'hE0, 1'b0);
        tick();
        beat("t6_b1", 64'hE1, 1'b0);
        tick();
        beat("t6_b2_pre", 64'hE2, 1'b0);
        WREADY = 1'b0;
        ARESET = 1'b1;
        #1;
        check_reset("t6_rst");
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        tick();
        push(64'hF0);
        push(64'hF1);
        burst_valid = 1'b1; burst_len = 8'd1; burst_tag = 4'd4;
        tick();
        burst_valid = 1'b0;
        WREADY = 1'b1;
        beat("t6_f0", 64'hF0, 1'b0);
        tick();
        beat("t6_f1", 64'hF1, 1'b1);
        tick();
        check("t6_done", 64'(burst_done), 64'd1);
        check("t6_done_tag", 64'(burst_done_tag), 64'd4);
        check("t6_count0", 64'(wdf_count), 64'd0);
        WREADY = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
